// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame decoder slice.
package spi_frame_pkg;

  localparam int WIDTH_SPI_WORD   = 8;
  localparam int WIDTH_ADDR_ACT   = 12;
  localparam int WIDTH_ACT_MEM    = 8;
  localparam int WIDTH_ADDR_PARAM = 13;
  localparam int WIDTH_PARAM_MEM  = 128;
  localparam int WIDTH_ADDR_INST  = 6;
  localparam int WIDTH_INST_MEM   = 80;

  localparam int READ_TURNAROUND_BYTES = 2;

  typedef enum logic [1:0] {
    TGT_CTRL  = 2'b00,
    TGT_PARAM = 2'b01,
    TGT_ACT   = 2'b10,
    TGT_INST  = 2'b11
  } target_e;

  localparam logic [3:0] CMD_DISABLE = 4'hC;
  localparam logic [3:0] CMD_RESET   = 4'hD;
  localparam logic [3:0] CMD_ENABLE  = 4'hE;
  localparam logic [3:0] CMD_STATUS  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WDATA,
    ST_RTURN,
    ST_RDATA,
    ST_SINK
  } state_e;

  // Number of SPI bytes that make up one memory word of the given target.
  function automatic logic [4:0] word_bytes(input target_e tgt);
    case (tgt)
      TGT_PARAM: word_bytes = 5'd16;
      TGT_INST:  word_bytes = 5'd10;
      TGT_ACT:   word_bytes = 5'd1;
      default:   word_bytes = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/spi_frame_decoder_if.sv
// Memory write/read and processor control bus driven by the SPI frame decoder.
interface spi_frame_decoder_if;

  logic                                      act_wr_en;
  logic [spi_frame_pkg::WIDTH_ADDR_ACT-1:0]   act_wr_addr;
  logic [spi_frame_pkg::WIDTH_ACT_MEM-1:0]    act_wr_data;
  logic                                      param_wr_en;
  logic [spi_frame_pkg::WIDTH_ADDR_PARAM-1:0] param_wr_addr;
  logic [spi_frame_pkg::WIDTH_PARAM_MEM-1:0]  param_wr_data;
  logic                                      inst_wr_en;
  logic [spi_frame_pkg::WIDTH_ADDR_INST-1:0]  inst_wr_addr;
  logic [spi_frame_pkg::WIDTH_INST_MEM-1:0]   inst_wr_data;
  logic                                      act_rd_en;
  logic [spi_frame_pkg::WIDTH_ADDR_ACT-1:0]   act_rd_addr;
  logic [spi_frame_pkg::WIDTH_ACT_MEM-1:0]    act_rd_data;
  logic                                      proc_enable;
  logic                                      soft_reset;

  modport master (
    output act_wr_en, act_wr_addr, act_wr_data,
    output param_wr_en, param_wr_addr, param_wr_data,
    output inst_wr_en, inst_wr_addr, inst_wr_data,
    output act_rd_en, act_rd_addr,
    input  act_rd_data,
    output proc_enable, soft_reset
  );

  modport slave (
    input  act_wr_en, act_wr_addr, act_wr_data,
    input  param_wr_en, param_wr_addr, param_wr_data,
    input  inst_wr_en, inst_wr_addr, inst_wr_data,
    input  act_rd_en, act_rd_addr,
    output act_rd_data,
    input  proc_enable, soft_reset
  );

endinterface

// File: rtl/spi_byte_shifter.sv
// Oversampling SPI mode-0 byte shifter: pin synchronizers, edge detection, RX/TX shift registers.
module spi_byte_shifter
  import spi_frame_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      spi_clk,
  input  logic                      mosi,
  input  logic                      chip_select_n,
  input  logic                      tx_load,
  input  logic [WIDTH_SPI_WORD-1:0] tx_byte,
  output logic                      byte_valid,
  output logic [WIDTH_SPI_WORD-1:0] byte_data,
  output logic                      frame_start,
  output logic                      frame_end,
  output logic                      miso
);

  logic [1:0] sclk_sync_r;
  logic [1:0] cs_sync_r;
  logic [1:0] mosi_sync_r;
  logic       sclk_d_r;
  logic       cs_d_r;
  logic [2:0] bit_cnt_r;
  logic [WIDTH_SPI_WORD-2:0] rx_shift_r;
  logic [WIDTH_SPI_WORD-1:0] tx_shift_r;
  logic       sclk_rise_s;
  logic       sclk_fall_s;
  logic       cs_active_s;

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_d_r;
  assign cs_active_s = ~cs_sync_r[1];
  assign miso        = tx_shift_r[WIDTH_SPI_WORD-1];

  // Two-flop synchronizers plus one history flop for edge detection.
  // Reset to low so a CS held low across reset does not look like a new frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sync_r <= 2'b00;
      cs_sync_r   <= 2'b00;
      mosi_sync_r <= 2'b00;
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], spi_clk};
      cs_sync_r   <= {cs_sync_r[0], chip_select_n};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      sclk_d_r    <= sclk_sync_r[1];
      cs_d_r      <= cs_sync_r[1];
    end
  end

  // Bit counting, byte assembly, frame strobes and MISO shifting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt_r   <= 3'd0;
      rx_shift_r  <= '0;
      tx_shift_r  <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= cs_d_r & ~cs_sync_r[1];
      frame_end   <= ~cs_d_r & cs_sync_r[1];
      if (!cs_active_s) begin
        bit_cnt_r  <= 3'd0;
        rx_shift_r <= '0;
      end else if (sclk_rise_s) begin
        rx_shift_r <= {rx_shift_r[WIDTH_SPI_WORD-3:0], mosi_sync_r[1]};
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {rx_shift_r, mosi_sync_r[1]};
        end
      end
      // The fall right after a byte boundary keeps the freshly loaded MSB on the pin.
      if (!cs_active_s) begin
        tx_shift_r <= '0;
      end else if (tx_load) begin
        tx_shift_r <= tx_byte;
      end else if (sclk_fall_s && (bit_cnt_r != 3'd0)) begin
        tx_shift_r <= {tx_shift_r[WIDTH_SPI_WORD-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_frame_decoder.sv
// SPI slave frame decoder: control commands, burst writes to act/param/inst memories, act readback.
// Defining SPI_STATUS_CMD_EN adds the status command (code 0x0F) returning {done_in, proc_enable}.
module spi_frame_decoder
  import spi_frame_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic MOSI,
  input  logic chip_select_n,
  output logic MISO,
  input  logic done_in,
  spi_frame_decoder_if.master mem
);

  state_e  state_r;
  state_e  state_nx_s;
  target_e tgt_s;
  target_e tgt_r;
  logic                         byte_valid_s;
  logic                         frame_start_s;
  logic                         frame_end_s;
  logic [WIDTH_SPI_WORD-1:0]    byte_data_s;
  logic                         rd_r;
  logic [15:0]                  addr_r;
  logic [4:0]                   byte_cnt_r;
  logic [WIDTH_PARAM_MEM-9:0]   word_r;
  logic [WIDTH_ACT_MEM-1:0]     hold_r;
  logic                         rd_capture_r;
  logic                         tx_load_r;
  logic [WIDTH_SPI_WORD-1:0]    tx_byte_r;
  logic hdr_take_s, ctrl_take_s, ahi_take_s, alo_take_s;
  logic wbyte_take_s, turn_take_s, rdata_take_s;
  logic turn_last_s;

  spi_byte_shifter u_shifter (
    .clk           (clk),
    .reset_n       (reset_n),
    .spi_clk       (spi_clk),
    .mosi          (MOSI),
    .chip_select_n (chip_select_n),
    .tx_load       (tx_load_r),
    .tx_byte       (tx_byte_r),
    .byte_valid    (byte_valid_s),
    .byte_data     (byte_data_s),
    .frame_start   (frame_start_s),
    .frame_end     (frame_end_s),
    .miso          (MISO)
  );

`ifndef SPI_STATUS_CMD_EN
  logic unused_done_s;
  assign unused_done_s = done_in;
`endif

  assign tgt_s       = target_e'(byte_data_s[7:6]);
  assign turn_last_s = (byte_cnt_r == 5'(READ_TURNAROUND_BYTES - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and per-byte action strobes; CS rise wins over everything.
  always_comb begin
    state_nx_s   = state_r;
    hdr_take_s   = 1'b0;
    ctrl_take_s  = 1'b0;
    ahi_take_s   = 1'b0;
    alo_take_s   = 1'b0;
    wbyte_take_s = 1'b0;
    turn_take_s  = 1'b0;
    rdata_take_s = 1'b0;
    if (frame_end_s) begin
      state_nx_s = ST_IDLE;
    end else if (byte_valid_s) begin
      case (state_r)
        ST_HEADER: begin
          hdr_take_s = 1'b1;
          if (tgt_s == TGT_CTRL) begin
            ctrl_take_s = 1'b1;
            state_nx_s  = ST_SINK;
          end else if (byte_data_s[5] && (tgt_s != TGT_ACT)) begin
            state_nx_s = ST_SINK;
          end else begin
            state_nx_s = ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          ahi_take_s = 1'b1;
          state_nx_s = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          alo_take_s = 1'b1;
          state_nx_s = rd_r ? ST_RTURN : ST_WDATA;
        end
        ST_WDATA: wbyte_take_s = 1'b1;
        ST_RTURN: begin
          turn_take_s = 1'b1;
          if (turn_last_s) begin
            state_nx_s = ST_RDATA;
          end else begin
            state_nx_s = ST_RTURN;
          end
        end
        ST_RDATA: rdata_take_s = 1'b1;
        default:  state_nx_s = state_r;
      endcase
    end else if (frame_start_s && (state_r == ST_IDLE)) begin
      state_nx_s = ST_HEADER;
    end else begin
      state_nx_s = state_r;
    end
  end

  // Frame datapath: address/word assembly, memory strobes, readback pipeline, control outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tgt_r             <= TGT_CTRL;
      rd_r              <= 1'b0;
      addr_r            <= 16'd0;
      byte_cnt_r        <= 5'd0;
      word_r            <= '0;
      hold_r            <= '0;
      rd_capture_r      <= 1'b0;
      tx_load_r         <= 1'b0;
      tx_byte_r         <= '0;
      mem.act_wr_en     <= 1'b0;
      mem.act_wr_addr   <= '0;
      mem.act_wr_data   <= '0;
      mem.param_wr_en   <= 1'b0;
      mem.param_wr_addr <= '0;
      mem.param_wr_data <= '0;
      mem.inst_wr_en    <= 1'b0;
      mem.inst_wr_addr  <= '0;
      mem.inst_wr_data  <= '0;
      mem.act_rd_en     <= 1'b0;
      mem.act_rd_addr   <= '0;
      mem.proc_enable   <= 1'b0;
      mem.soft_reset    <= 1'b0;
    end else begin
      mem.act_wr_en   <= 1'b0;
      mem.param_wr_en <= 1'b0;
      mem.inst_wr_en  <= 1'b0;
      mem.act_rd_en   <= 1'b0;
      mem.soft_reset  <= 1'b0;
      tx_load_r       <= 1'b0;
      rd_capture_r    <= mem.act_rd_en;
      if (rd_capture_r) begin
        hold_r <= mem.act_rd_data;
      end
      if (frame_end_s) begin
        byte_cnt_r <= 5'd0;
      end
      if (hdr_take_s) begin
        tgt_r      <= tgt_s;
        rd_r       <= byte_data_s[5];
        byte_cnt_r <= 5'd0;
      end
      if (ctrl_take_s) begin
        case (byte_data_s[3:0])
          CMD_DISABLE: mem.proc_enable <= 1'b0;
          CMD_RESET:   mem.soft_reset  <= 1'b1;
          CMD_ENABLE:  mem.proc_enable <= 1'b1;
`ifdef SPI_STATUS_CMD_EN
          CMD_STATUS: begin
            tx_load_r <= 1'b1;
            tx_byte_r <= {6'b000000, done_in, mem.proc_enable};
          end
`endif
          default: ;
        endcase
      end
      if (ahi_take_s) begin
        addr_r[15:8] <= byte_data_s;
      end
      if (alo_take_s) begin
        addr_r[7:0] <= byte_data_s;
      end
      if (wbyte_take_s) begin
        word_r <= {word_r[WIDTH_PARAM_MEM-17:0], byte_data_s};
        if (byte_cnt_r == (word_bytes(tgt_r) - 5'd1)) begin
          byte_cnt_r <= 5'd0;
          addr_r     <= addr_r + 16'd1;
          case (tgt_r)
            TGT_ACT: begin
              mem.act_wr_en   <= 1'b1;
              mem.act_wr_addr <= addr_r[WIDTH_ADDR_ACT-1:0];
              mem.act_wr_data <= byte_data_s;
            end
            TGT_PARAM: begin
              mem.param_wr_en   <= 1'b1;
              mem.param_wr_addr <= addr_r[WIDTH_ADDR_PARAM-1:0];
              mem.param_wr_data <= {word_r, byte_data_s};
            end
            TGT_INST: begin
              mem.inst_wr_en   <= 1'b1;
              mem.inst_wr_addr <= addr_r[WIDTH_ADDR_INST-1:0];
              mem.inst_wr_data <= {word_r[WIDTH_INST_MEM-9:0], byte_data_s};
            end
            default: ;
          endcase
        end else begin
          byte_cnt_r <= byte_cnt_r + 5'd1;
        end
      end
      // First turnaround byte primes the read; every shifter load then fetches the next address.
      if (turn_take_s || rdata_take_s) begin
        if (rdata_take_s || turn_last_s) begin
          tx_load_r <= 1'b1;
          tx_byte_r <= hold_r;
        end
        if (rdata_take_s || turn_last_s || (byte_cnt_r == 5'd0)) begin
          mem.act_rd_en   <= 1'b1;
          mem.act_rd_addr <= addr_r[WIDTH_ADDR_ACT-1:0];
          addr_r          <= addr_r + 16'd1;
        end
        if (turn_take_s) begin
          byte_cnt_r <= byte_cnt_r + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: bit-banged SPI master, write scoreboard, readback memory model.
module tb_spi_frame_decoder;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic reset_n;
  logic spi_clk;
  logic mosi;
  logic cs_n;
  logic miso;
  logic done_in;

  spi_frame_decoder_if mem_if ();

  spi_frame_decoder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .spi_clk       (spi_clk),
    .MOSI          (mosi),
    .chip_select_n (cs_n),
    .MISO          (miso),
    .done_in       (done_in),
    .mem           (mem_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           kind;
    logic [15:0]  addr;
    logic [127:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] act_mem [0:4095];
  logic [7:0] tx_buf  [0:31];
  logic [7:0] rx_buf  [0:31];

  int sr_run = 0;
  int sr_pulses = 0;
  int sr_maxrun = 0;
  int param_pulses = 0;

  always @(posedge clk) begin
    if (!reset_n) mem_if.act_rd_data <= 8'h00;
    else if (mem_if.act_rd_en) mem_if.act_rd_data <= act_mem[mem_if.act_rd_addr];
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic expect_wr(input int kind, input logic [15:0] addr, input logic [127:0] data);
    wr_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic got_wr(input int kind, input logic [15:0] addr, input logic [127:0] data);
    wr_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_write: kind %0d addr %0h data %0h, none expected", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== addr || e.data !== data) begin
        errors++;
        $display("FAIL write: got kind %0d addr %0h data %0h expected kind %0d addr %0h data %0h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: compares every write pulse against the scoreboard and tracks soft_reset pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_if.act_wr_en)
          got_wr(0, 16'(mem_if.act_wr_addr), 128'(mem_if.act_wr_data));
        if (mem_if.param_wr_en) begin
          param_pulses++;
          got_wr(1, 16'(mem_if.param_wr_addr), mem_if.param_wr_data);
        end
        if (mem_if.inst_wr_en)
          got_wr(2, 16'(mem_if.inst_wr_addr), 128'(mem_if.inst_wr_data));
      end
      if (mem_if.soft_reset) begin
        sr_run++;
        if (sr_run == 1) sr_pulses++;
        if (sr_run > sr_maxrun) sr_maxrun = sr_run;
      end else begin
        sr_run = 0;
      end
    end
  end

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input int n);
    logic [7:0] rb;
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < n; b++) begin
      spi_xfer(tx_buf[b], rb);
      rx_buf[b] = rb;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) act_mem[i] = 8'h00;
    act_mem[12'h020] = 8'hA1;
    act_mem[12'h021] = 8'hB2;
    act_mem[12'h022] = 8'hC3;
    reset_n = 1'b0;
    spi_clk = 1'b0;
    mosi    = 1'b0;
    cs_n    = 1'b1;
    done_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_proc_enable", 128'(mem_if.proc_enable), 128'h0);
    chk("rst_soft_reset", 128'(mem_if.soft_reset), 128'h0);
    chk("rst_miso", 128'(miso), 128'h0);
    chk("rst_wr_enables", 128'({mem_if.act_wr_en, mem_if.param_wr_en, mem_if.inst_wr_en, mem_if.act_rd_en}), 128'h0);
    chk("rst_act_wr_addr", 128'(mem_if.act_wr_addr), 128'h0);
    chk("rst_param_wr_data", mem_if.param_wr_data, 128'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    tx_buf[0] = 8'h0E; send_frame(1);
    chk("enable_cmd", 128'(mem_if.proc_enable), 128'h1);
    tx_buf[0] = 8'h0D; send_frame(1);
    chk("soft_reset_pulses", 128'(sr_pulses), 128'h1);
    chk("soft_reset_width", 128'(sr_maxrun), 128'h1);
    chk("enable_after_reset_cmd", 128'(mem_if.proc_enable), 128'h1);
    tx_buf[0] = 8'h0C; send_frame(1);
    chk("disable_cmd", 128'(mem_if.proc_enable), 128'h0);

    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00; tx_buf[2] = 8'h10; tx_buf[3] = 8'h11; tx_buf[4] = 8'h22;
    expect_wr(0, 16'h010, 128'h11);
    expect_wr(0, 16'h011, 128'h22);
    send_frame(5);
    chk("act_burst_all_seen", 128'(exp_q.size()), 128'h0);

    tx_buf[0] = 8'h40; tx_buf[1] = 8'h00; tx_buf[2] = 8'h05;
    for (int i = 0; i < 16; i++) tx_buf[3 + i] = 8'(i);
    expect_wr(1, 16'h0005, 128'h000102030405060708090A0B0C0D0E0F);
    send_frame(19);
    chk("param_write_seen", 128'(exp_q.size()), 128'h0);

    tx_buf[0] = 8'hC0; tx_buf[1] = 8'h12; tx_buf[2] = 8'h47;
    for (int i = 0; i < 10; i++) tx_buf[3 + i] = 8'(8'h10 + i);
    expect_wr(2, 16'h07, 128'h10111213141516171819);
    send_frame(13);
    chk("inst_write_seen", 128'(exp_q.size()), 128'h0);

    tx_buf[0] = 8'h80; tx_buf[1] = 8'h0F; tx_buf[2] = 8'hFF; tx_buf[3] = 8'h5A; tx_buf[4] = 8'hA5;
    expect_wr(0, 16'hFFF, 128'h5A);
    expect_wr(0, 16'h000, 128'hA5);
    send_frame(5);
    chk("act_wrap_seen", 128'(exp_q.size()), 128'h0);

    tx_buf[0] = 8'hA0; tx_buf[1] = 8'h00; tx_buf[2] = 8'h20;
    for (int i = 3; i < 8; i++) tx_buf[i] = 8'hFF;
    send_frame(8);
    chk("read_turnaround_miso", 128'(rx_buf[4]), 128'h00);
    chk("read_byte6", 128'(rx_buf[5]), 128'hA1);
    chk("read_byte7", 128'(rx_buf[6]), 128'hB2);
    chk("read_byte8", 128'(rx_buf[7]), 128'hC3);

    tx_buf[0] = 8'h60; tx_buf[1] = 8'hFF; tx_buf[2] = 8'hFF; tx_buf[3] = 8'hFF;
    send_frame(4);
    chk("param_read_sink_miso", 128'({rx_buf[1], rx_buf[3]}), 128'h0);

    tx_buf[0] = 8'h40; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    for (int i = 0; i < 5; i++) tx_buf[3 + i] = 8'hEE;
    send_frame(8);
    chk("abort_no_param_write", 128'(param_pulses), 128'h1);
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h01; tx_buf[2] = 8'h23; tx_buf[3] = 8'h77;
    expect_wr(0, 16'h123, 128'h77);
    send_frame(4);
    chk("after_abort_write_seen", 128'(exp_q.size()), 128'h0);

    tx_buf[0] = 8'h0E; send_frame(1);
    done_in = 1'b1;
    tx_buf[0] = 8'h0F; tx_buf[1] = 8'h00;
    send_frame(2);
`ifdef SPI_STATUS_CMD_EN
    chk("status_byte", 128'(rx_buf[1]), 128'h03);
`else
    chk("status_ignored", 128'(rx_buf[1]), 128'h00);
`endif
    chk("status_keeps_enable", 128'(mem_if.proc_enable), 128'h1);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
